// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format codes, RV base opcodes
// and the decoded-entry record stored in the stage's buffer slots.
package imm_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Fields are sized for the widest XLEN; narrower builds leave the top bits zero.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] target;
        logic [XLEN_MAX-1:0] pc;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational decode of one instruction and its PC into a dec_t record:
// format, sign-extended immediate and PC-relative target.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_t            dec
);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            pc_rel;

    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // The 32-bit word opcodes only exist on RV64; on RV32 they fall through as illegal.
    always_comb begin
        fmt    = FMT_NONE;
        pc_rel = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            OPC_OP_IMM_32: fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OPC_STORE:     fmt = FMT_S;
            OPC_BRANCH: begin
                fmt    = FMT_B;
                pc_rel = 1'b1;
            end
            OPC_LUI:       fmt = FMT_U;
            OPC_AUIPC: begin
                fmt    = FMT_U;
                pc_rel = 1'b1;
            end
            OPC_JAL: begin
                fmt    = FMT_J;
                pc_rel = 1'b1;
            end
            OPC_OP:        fmt = FMT_R;
            OPC_OP_32:     fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            default:       fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = imm_i;
            FMT_S:   imm = imm_s;
            FMT_B:   imm = imm_b;
            FMT_U:   imm = imm_u;
            FMT_J:   imm = imm_j;
            default: imm = '0;
        endcase
    end

    assign target = pc_rel ? (pc + imm) : '0;

    assign dec.imm     = XLEN_MAX'(imm);
    assign dec.fmt     = fmt;
    assign dec.target  = XLEN_MAX'(target);
    assign dec.pc      = XLEN_MAX'(pc);
    assign dec.illegal = (fmt == FMT_NONE);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes on the way in, holds results in a
// main/skid slot pair so back-pressure never drops or reorders entries.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    dec_t             dec;
    dec_t             main_q;
    dec_t             skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             leave;
    logic [CNT_W-1:0] cnt_q;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr(in_instr),
        .pc   (in_pc),
        .dec  (dec)
    );

    // in_ready depends only on slot state and reset, never on out_ready.
    assign in_ready = !skid_valid && !reset;
    assign accept   = in_valid && in_ready && !flush;
    assign leave    = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept && dec.illegal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid || leave) begin
                // Skid is only ever full while main is full, so it always refills main first.
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    generate
        if (XLEN < XLEN_MAX) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN],
                                 main_q.target[XLEN_MAX-1:XLEN],
                                 main_q.pc[XLEN_MAX-1:XLEN]};
        end
    endgenerate

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target[XLEN-1:0];
    assign out_pc      = main_q.pc[XLEN-1:0];
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
